vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- DIV, 4, clk cycles per pixel (1..16)
- SYNC_POL, 1'b0, asserted level of hsync/vsync
- SYNC_DELAY, 1, pixel ticks of hsync/vsync lag behind counters (0..3)

REQ-002 Ports SHALL be (name, direction, width, meaning). One clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en  in  1  run enable
- pix_en  out  1  one-clk pixel strobe
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  pixel inside active area
- h_cnt  out  CNT_W  horizontal position
- v_cnt  out  CNT_W  vertical position
- line_start  out  1  one-clk pulse, first pixel of line
- frame_start  out  1  one-clk pulse, first pixel of frame

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; CNT_W = clog2(max(H_TOTAL,V_TOTAL)).
REQ-004 Illegal parameters (any timing field 0, DIV outside 1..16, SYNC_DELAY outside 0..3) SHALL fail elaboration.
REQ-005 Divider counts 0..DIV-1 while en=1; pix_en=1 for exactly the clk where the divider reaches DIV-1; DIV=1 gives pix_en=1 on every clk while en=1.
REQ-006 On each pix_en, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0 on the same tick.
REQ-007 valid SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, in the same cycle as those counter values.
REQ-008 Undelayed hsync SHALL be SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vsync likewise on v_cnt.
REQ-009 hsync/vsync SHALL pass through a SYNC_DELAY-stage register chain advanced only on pix_en; SYNC_DELAY=0 aligns them with the counters.
REQ-010 line_start=1 for one clk when h_cnt becomes 0; frame_start=1 for one clk when h_cnt and v_cnt both become 0; both coincide with that clk's pix_en.
REQ-011 All outputs SHALL be registered; no combinational path from en to any output.
REQ-012 en=0 SHALL synchronously clear divider, counters and delay chain to reset values; the first pix_en comes DIV clks after en returns to 1.
REQ-013 en toggling mid-frame SHALL restart at h=0,v=0; no partial-line pulses are emitted.

Reset
REQ-014 While rst=0: pix_en=0, h_cnt=0, v_cnt=0, valid=0, line_start=0, frame_start=0, hsync=vsync=~SYNC_POL, delay chain=~SYNC_POL.
REQ-015 After rst rises with en=1, behaviour SHALL match REQ-012 (first pix_en DIV clks later); reset asserted mid-frame takes effect immediately and asynchronously.

Structure
REQ-016 Shared package vga_pkg SHALL hold the timing struct typedef, the 640x480@60 default constants and the CNT_W width function.
REQ-017 One sub-module vga_axis_counter (count, wrap, sync-window and active decode) SHALL be instantiated once for horizontal and once for vertical timing.

Verification (defaults unless stated)
REQ-018 Release rst with en=1 -> first pix_en 4 clks later; pix_en period 4 clks; h_cnt wraps 799->0; frame_start period 1,680,000 clks.
REQ-019 Sample hsync at h_cnt 655/656/751/752 with SYNC_DELAY=0 -> 1/0/0/1; vsync 0 exactly on v_cnt 490..491.
REQ-020 SYNC_DELAY=3 -> hsync falling edge at h_cnt=659, exactly 3 pix_en after the SYNC_DELAY=0 position.
REQ-021 Drop en at h=300,v=200 for 10 clks -> outputs at reset values; after re-enable, first pix_en 4 clks later with h_cnt=0, v_cnt=0, frame_start=1.
REQ-022 DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> pix_en constant 1, line period 14 clks, frame period 98 clks, valid high 32 clks per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing types, 640x480@60 defaults and counter-width helper.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    typedef enum logic {
        RUN_WAIT   = 1'b0,
        RUN_ACTIVE = 1'b1
    } vga_run_e;

    localparam vga_axis_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_axis_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};
    localparam int unsigned VGA_640X480_DIV = 4;

    function automatic int unsigned vga_axis_total(vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic int unsigned vga_cnt_w(int unsigned h_total, int unsigned v_total);
        return $clog2((h_total > v_total) ? h_total : v_total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap, plus active/sync decode of the next value.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_axis_t   TIMING = VGA_640X480_H,
    parameter int unsigned W      = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         tick_i,
    input  logic         restart_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         zero_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int unsigned TOTAL      = vga_axis_total(TIMING);
    localparam int unsigned SYNC_START = TIMING.active + TIMING.fp;
    localparam int unsigned SYNC_END   = SYNC_START + TIMING.sync;
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = inc_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (restart_i || wrap_o) begin
                cnt_d = '0;
            end else if (inc_i) begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decodes look at the value being loaded so the registered flags line up with cnt_o.
    assign zero_o   = (cnt_d == '0);
    assign active_o = (cnt_d < W'(TIMING.active));
    assign sync_o   = (cnt_d >= W'(SYNC_START)) && (cnt_d < W'(SYNC_END));
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, delayed syncs, start pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_640X480_H.active,
    parameter int unsigned H_FP       = VGA_640X480_H.fp,
    parameter int unsigned H_SYNC     = VGA_640X480_H.sync,
    parameter int unsigned H_BP       = VGA_640X480_H.bp,
    parameter int unsigned V_ACTIVE   = VGA_640X480_V.active,
    parameter int unsigned V_FP       = VGA_640X480_V.fp,
    parameter int unsigned V_SYNC     = VGA_640X480_V.sync,
    parameter int unsigned V_BP       = VGA_640X480_V.bp,
    parameter int unsigned DIV        = VGA_640X480_DIV,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned SYNC_DELAY = 1,
    localparam int unsigned CNT_W = vga_cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP,
                                              V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_start,
    output logic             frame_start
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: timing fields must be non-zero");
    end
    if (DIV < 1 || DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: DIV must be 1..16");
    end
    if (SYNC_DELAY > 3) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..3");
    end

    localparam vga_axis_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_axis_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
    localparam logic [SYNC_DELAY:0] SYNC_IDLE = {(SYNC_DELAY + 1){~SYNC_POL}};

    logic [3:0]        div_q, div_d;
    vga_run_e          run_q, run_d;
    logic              pix_en_q, pix_en_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              valid_q, valid_d;
    logic [SYNC_DELAY:0] hs_q, hs_d, vs_q, vs_d;
    logic [SYNC_DELAY:0] hs_shift, vs_shift;
    logic              tick, hs_new, vs_new;
    logic              h_wrap, h_zero, h_active, h_sync;
    logic              v_wrap_unused, v_zero, v_active, v_sync;

    assign tick = en && (div_q == DIV_LAST);

    vga_axis_counter #(.TIMING(H_TIMING), .W(CNT_W)) u_h_axis (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .clr_i     (!en),
        .tick_i    (tick),
        .restart_i (run_q == RUN_WAIT),
        .inc_i     (1'b1),
        .cnt_o     (h_cnt),
        .wrap_o    (h_wrap),
        .zero_o    (h_zero),
        .active_o  (h_active),
        .sync_o    (h_sync)
    );

    vga_axis_counter #(.TIMING(V_TIMING), .W(CNT_W)) u_v_axis (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .clr_i     (!en),
        .tick_i    (tick),
        .restart_i (run_q == RUN_WAIT),
        .inc_i     (h_wrap),
        .cnt_o     (v_cnt),
        .wrap_o    (v_wrap_unused),
        .zero_o    (v_zero),
        .active_o  (v_active),
        .sync_o    (v_sync)
    );

    assign hs_new = h_sync ? SYNC_POL : ~SYNC_POL;
    assign vs_new = v_sync ? SYNC_POL : ~SYNC_POL;

    // Stage 0 always holds the undelayed sync; output taps stage SYNC_DELAY.
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hs_shift = hs_new;
        assign vs_shift = vs_new;
    end else begin : g_delay
        assign hs_shift = {hs_q[SYNC_DELAY-1:0], hs_new};
        assign vs_shift = {vs_q[SYNC_DELAY-1:0], vs_new};
    end

    always_comb begin
        div_d         = div_q;
        run_d         = run_q;
        pix_en_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        valid_d       = valid_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (!en) begin
            div_d   = '0;
            run_d   = RUN_WAIT;
            valid_d = 1'b0;
            hs_d    = SYNC_IDLE;
            vs_d    = SYNC_IDLE;
        end else if (tick) begin
            div_d         = '0;
            run_d         = RUN_ACTIVE;
            pix_en_d      = 1'b1;
            line_start_d  = h_zero;
            frame_start_d = h_zero && v_zero;
            valid_d       = h_active && v_active;
            hs_d          = hs_shift;
            vs_d          = vs_shift;
        end else begin
            div_d = div_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            run_q         <= RUN_WAIT;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            valid_q       <= 1'b0;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
        end else begin
            div_q         <= div_d;
            run_q         <= run_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            valid_q       <= valid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign valid       = valid_q;
    assign hsync       = hs_q[SYNC_DELAY];
    assign vsync       = vs_q[SYNC_DELAY];

endmodule
